// File: rtl/dnn_result_reader.sv
// Argmax reader: on a done rising edge, sweeps NUM_OUT engine scores and holds the winning class until cls_ready.
// Define DNN_RD_SCORE_EN to also expose the winning score; latency is NUM_OUT+1 cycles from the done edge to cls_valid.
module dnn_result_reader #(
  parameter int DATA_WIDTH = 13,
  parameter int NUM_OUT    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         done,
  output logic [3:0]                   out_idx,
  input  logic signed [DATA_WIDTH-1:0] out,
  output logic                         cls_valid,
  input  logic                         cls_ready,
  output logic [3:0]                   cls,
  output logic                         overrun
`ifdef DNN_RD_SCORE_EN
  ,
  output logic signed [DATA_WIDTH-1:0] score
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NUM_OUT - 1);

  logic [1:0]                   state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic                         done_q;
  logic                         armed_q;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [3:0]                   max_idx_q, max_idx_d;
  logic [3:0]                   cls_q, cls_d;
  logic                         overrun_q, overrun_d;
`ifdef DNN_RD_SCORE_EN
  logic signed [DATA_WIDTH-1:0] score_q, score_d;
`endif

  logic                         done_rise;
  logic                         done_fall;
  logic                         take_new;
  logic signed [DATA_WIDTH-1:0] samp_max;
  logic [3:0]                   samp_idx;

  // armed_q masks the first cycle after reset so a done already high at release is not seen as an edge.
  assign done_rise = done & ~done_q & armed_q;
  assign done_fall = ~done & done_q;

  // Strict greater-than keeps the lower index on ties.
  assign take_new = (idx_q == 4'd0) || (out > max_q);
  assign samp_max = take_new ? out : max_q;
  assign samp_idx = take_new ? idx_q : max_idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    cls_d     = cls_q;
    overrun_d = overrun_q;
`ifdef DNN_RD_SCORE_EN
    score_d   = score_q;
`endif
    if (clr) begin
      state_d   = IDLE;
      idx_d     = 4'd0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (done_rise) begin
            state_d = SCAN;
            idx_d   = 4'd0;
          end
        end
        SCAN: begin
          if (done_rise) overrun_d = 1'b1;
          if (done_fall) begin
            state_d = IDLE;
            idx_d   = 4'd0;
          end else begin
            max_d     = samp_max;
            max_idx_d = samp_idx;
            if (idx_q == LAST_IDX) begin
              state_d = HOLD;
              idx_d   = 4'd0;
              cls_d   = samp_idx;
`ifdef DNN_RD_SCORE_EN
              score_d = samp_max;
`endif
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (done_rise) overrun_d = 1'b1;
          if (cls_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      max_q     <= '0;
      max_idx_q <= 4'd0;
      cls_q     <= 4'd0;
      overrun_q <= 1'b0;
`ifdef DNN_RD_SCORE_EN
      score_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done;
      armed_q   <= 1'b1;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      cls_q     <= cls_d;
      overrun_q <= overrun_d;
`ifdef DNN_RD_SCORE_EN
      score_q   <= score_d;
`endif
    end
  end

  assign out_idx   = (state_q == SCAN) ? idx_q : 4'd0;
  assign cls_valid = (state_q == HOLD);
  assign cls       = cls_q;
  assign overrun   = overrun_q;
`ifdef DNN_RD_SCORE_EN
  assign score     = score_q;
`endif

endmodule

// File: tb/tb_dnn_result_reader.sv
// Scoreboard bench for dnn_result_reader: expected argmax pushed per scan, popped on each valid/ready transfer.
module tb_dnn_result_reader;

  localparam int DW = 13;
  localparam int NO = 10;

  logic                 clk;
  logic                 rst;
  logic                 clr;
  logic                 done;
  logic [3:0]           out_idx;
  logic signed [DW-1:0] out;
  logic                 cls_valid;
  logic                 cls_ready;
  logic [3:0]           cls;
  logic                 overrun;
`ifdef DNN_RD_SCORE_EN
  logic signed [DW-1:0] score;
`endif

  logic signed [DW-1:0] scores [16];
  int exp_cls_q [$];
  int exp_score_q [$];
  int n_chk = 0;
  int n_err = 0;

  dnn_result_reader #(.DATA_WIDTH(DW), .NUM_OUT(NO)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .done      (done),
    .out_idx   (out_idx),
    .out       (out),
    .cls_valid (cls_valid),
    .cls_ready (cls_ready),
    .cls       (cls),
    .overrun   (overrun)
`ifdef DNN_RD_SCORE_EN
    ,
    .score     (score)
`endif
  );

  // Engine model: combinational score lookup.
  assign out = scores[out_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    int best;
    best = 0;
    for (int i = 1; i < NO; i++)
      if (scores[i] > scores[best]) best = i;
    exp_cls_q.push_back(best);
    exp_score_q.push_back(int'(scores[best]));
  endtask

  task automatic set_scores(input int v0, input int v1, input int v2, input int v3, input int v4,
                            input int v5, input int v6, input int v7, input int v8, input int v9);
    scores[0] = DW'(v0); scores[1] = DW'(v1); scores[2] = DW'(v2); scores[3] = DW'(v3);
    scores[4] = DW'(v4); scores[5] = DW'(v5); scores[6] = DW'(v6); scores[7] = DW'(v7);
    scores[8] = DW'(v8); scores[9] = DW'(v9);
  endtask

  task automatic rand_scores();
    for (int i = 0; i < NO; i++) scores[i] = DW'($urandom_range(0, 8191));
  endtask

  // Raises done, checks the index sweep, returns in the first HOLD cycle.
  task automatic run_scan(input string tag);
    push_expected();
    done = 1'b1;
    tick();
    for (int k = 0; k < NO; k++) begin
      chk({tag, "_idx"}, int'(out_idx), k);
      if (k == 0) chk({tag, "_nvld"}, int'(cls_valid), 0);
      tick();
    end
    chk({tag, "_vld"}, int'(cls_valid), 1);
  endtask

  task automatic finish_xfer(input string tag);
    done = 1'b0;
    tick();
    chk({tag, "_drop"}, int'(cls_valid), 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && cls_valid === 1'b1 && cls_ready === 1'b1) begin
      chk("sb_pending", int'(exp_cls_q.size() > 0), 1);
      if (exp_cls_q.size() > 0) begin
        chk("sb_cls", int'(cls), exp_cls_q.pop_front());
`ifdef DNN_RD_SCORE_EN
        chk("sb_score", int'(score), exp_score_q[0]);
`endif
        void'(exp_score_q.pop_front());
      end
    end
  end

  initial begin
    int held;
    rst = 1'b0; clr = 1'b0; done = 1'b0; cls_ready = 1'b0;
    for (int i = 0; i < 16; i++) scores[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_vld", int'(cls_valid), 0);
    chk("rst_cls", int'(cls), 0);
    chk("rst_ovr", int'(overrun), 0);
`ifdef DNN_RD_SCORE_EN
    chk("rst_score", int'(score), 0);
`endif
    rst = 1'b1;
    tick();

    // Basic sweep, winner at index 2.
    cls_ready = 1'b1;
    set_scores(5, -3, 100, 7, 0, 0, 0, 0, 0, 99);
    run_scan("basic");
    finish_xfer("basic");

    // All minimum, then a tie between indices 1 and 2.
    set_scores(-4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096);
    run_scan("allmin");
    finish_xfer("allmin");
    set_scores(3, 9, 9, 1, 0, 0, 0, 0, 0, 0);
    run_scan("tie");
    finish_xfer("tie");

    for (int r = 0; r < 3; r++) begin
      rand_scores();
      run_scan("rand");
      finish_xfer("rand");
    end

    // Backpressure: result held stable while cls_ready is low.
    cls_ready = 1'b0;
    rand_scores();
    run_scan("bp");
    held = exp_cls_q[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_vld", int'(cls_valid), 1);
      chk("bp_hold_cls", int'(cls), held);
      tick();
    end
    cls_ready = 1'b1;
    chk("bp_last_vld", int'(cls_valid), 1);
    tick();
    chk("bp_drop", int'(cls_valid), 0);
    done = 1'b0;
    tick();

    // done falls at scan cycle 4: abort without a result.
    set_scores(1, 2, 3, 4, 5, 6, 7, 500, 8, 9);
    done = 1'b1;
    tick();
    repeat (4) tick();
    chk("abort_idx4", int'(out_idx), 4);
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_nvld", int'(cls_valid), 0);
      chk("abort_idx0", int'(out_idx), 0);
    end
    run_scan("after_abort");
    finish_xfer("after_abort");

    // Overrun in HOLD, then clr.
    cls_ready = 1'b0;
    set_scores(0, -10, 20, 30, 400, 12, -400, 399, 0, 1);
    run_scan("ovr");
    held = exp_cls_q[0];
    done = 1'b0;
    tick();
    chk("ovr_fall_vld", int'(cls_valid), 1);
    chk("ovr_pre", int'(overrun), 0);
    done = 1'b1;
    tick();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_vld", int'(cls_valid), 1);
    chk("ovr_cls", int'(cls), held);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovr", int'(overrun), 0);
    chk("clr_vld", int'(cls_valid), 0);
    chk("clr_cls", int'(cls), held);
    chk("clr_idx", int'(out_idx), 0);
    void'(exp_cls_q.pop_front());
    void'(exp_score_q.pop_front());
    tick();
    chk("clr_idle_vld", int'(cls_valid), 0);
    done = 1'b0;
    tick();
    cls_ready = 1'b1;

    // Async reset mid-scan with done held across release.
    rand_scores();
    done = 1'b1;
    tick();
    repeat (6) tick();
    chk("rst_mid_idx6", int'(out_idx), 6);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_idx", int'(out_idx), 0);
    chk("arst_vld", int'(cls_valid), 0);
    chk("arst_cls", int'(cls), 0);
    chk("arst_ovr", int'(overrun), 0);
`ifdef DNN_RD_SCORE_EN
    chk("arst_score", int'(score), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("hi_rel_idx", int'(out_idx), 0);
      chk("hi_rel_vld", int'(cls_valid), 0);
    end
    done = 1'b0;
    tick();
    rand_scores();
    run_scan("recover");
    finish_xfer("recover");

    chk("sb_drain", exp_cls_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
